// File: rtl/led_out_pio_pkg.sv
// rtl/led_out_pio_pkg.sv - register map constants for the LED output PIO
package led_out_pio_pkg;

    // Word addresses of the slave register map
    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK   = 3'd1;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS       = 3'd3;
    localparam logic [2:0] ADDR_OUTSET       = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

    // Bit position of the blink phase inside STATUS
    localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/led_blink_timer.sv
// rtl/led_blink_timer.sv - prescaled half-period timer producing the blink phase
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   period   half-period length in prescaler ticks; 0 disables the timer
//   restart  one-cycle pulse that clears prescaler, period counter and phase
//   phase    0 = lit half, 1 = dark half
module led_blink_timer #(
    parameter int PRESCALE     = 50000,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    restart,
    output logic                    phase
);

    localparam int                 PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

    logic [PRESC_W-1:0]      r_presc;
    logic [PERIOD_WIDTH-1:0] r_per_cnt;
    logic                    r_phase;

    logic w_enabled;
    logic w_tick;
    logic w_per_last;

    assign w_enabled  = (period != '0);
    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_per_last = (r_per_cnt == (period - PERIOD_WIDTH'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc   <= '0;
            r_per_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (restart || !w_enabled) begin
            // A period rewrite always restarts from the lit phase; period 0 parks everything
            r_presc   <= '0;
            r_per_cnt <= '0;
            r_phase   <= 1'b0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                if (w_per_last) begin
                    r_per_cnt <= '0;
                    r_phase   <= ~r_phase;
                end else begin
                    r_per_cnt <= r_per_cnt + PERIOD_WIDTH'(1);
                end
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/led_out_pio.sv
// rtl/led_out_pio.sv - Avalon-MM output PIO with set/clear access and per-bit blink
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data, one cycle latency, updated every cycle
//   out_port    LED drive: data gated dark by blink mask during the dark phase
module led_out_pio
    import led_out_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
    parameter int                    PRESCALE     = 50000,
    parameter int                    PERIOD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   r_mask;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [31:0]             r_readdata;

    logic                    w_wr;
    logic                    w_restart;
    logic                    w_phase;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [31:0]             w_rd_next;
    logic                    w_unused;

    assign w_wr      = chipselect && !write_n;
    assign w_restart = w_wr && (address == ADDR_BLINK_PERIOD);
    assign w_wdata   = writedata[DATA_WIDTH-1:0];

    // Upper write data bits beyond the register widths are ignored
    assign w_unused  = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= RESET_VALUE;
            r_mask   <= '0;
            r_period <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:         r_data   <= w_wdata;
                ADDR_BLINK_MASK:   r_mask   <= w_wdata;
                ADDR_BLINK_PERIOD: r_period <= writedata[PERIOD_WIDTH-1:0];
                ADDR_OUTSET:       r_data   <= r_data | w_wdata;
                ADDR_OUTCLEAR:     r_data   <= r_data & ~w_wdata;
                default:           ;
            endcase
        end
    end

    always_comb begin
        w_rd_next = '0;
        case (address)
            ADDR_DATA:         w_rd_next[DATA_WIDTH-1:0]   = r_data;
            ADDR_BLINK_MASK:   w_rd_next[DATA_WIDTH-1:0]   = r_mask;
            ADDR_BLINK_PERIOD: w_rd_next[PERIOD_WIDTH-1:0] = r_period;
            ADDR_STATUS:       w_rd_next[STATUS_PHASE_BIT] = w_phase;
            default:           w_rd_next = '0;
        endcase
    end

    // Read data is captured every cycle so it always lags the address by one edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_next;
        end
    end

    led_blink_timer #(
        .PRESCALE     (PRESCALE),
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (r_period),
        .restart (w_restart),
        .phase   (w_phase)
    );

    assign readdata = r_readdata;
    assign out_port = r_data & ~(r_mask & {DATA_WIDTH{w_phase}});

endmodule

// File: tb/tb_led_out_pio.sv
// tb/tb_led_out_pio.sv - self-checking bench for led_out_pio
module tb_led_out_pio;
    import led_out_pio_pkg::*;

    localparam int         DW  = 8;
    localparam logic [7:0] RV  = 8'hA5;
    localparam logic [7:0] DIM = 8'h7E;

    logic        clk;
    logic        clk_en;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int errors;
    int checks;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic        cs;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  exp_out;
    } vec_t;
    vec_t vecs[8];

    typedef struct {
        string       name;
        logic [2:0]  addr;
        logic [31:0] exp;
    } rvec_t;
    rvec_t rvecs[7];

    led_out_pio #(
        .DATA_WIDTH   (DW),
        .RESET_VALUE  (RV),
        .PRESCALE     (4),
        .PERIOD_WIDTH (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%h req=%h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Expected readdata is queued when the address is driven and popped one edge later
    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        sb_t e;
        address = a;
        sb_q.push_back('{name, exp});
        @(negedge clk);
        e = sb_q.pop_front();
        chk(e.name, readdata, e.exp);
    endtask

    // Runs n cycles with STATUS addressed, checking out_port and the phase readback
    task automatic blink_run(input string name, input int n, input int half, input logic start_phase);
        sb_t        e;
        logic       ph;
        logic [7:0] exp_out;
        address = ADDR_STATUS;
        for (int i = 0; i < n; i++) begin
            ph      = start_phase ^ logic'((i / half) % 2);
            exp_out = ph ? DIM : 8'hFF;
            chk({name, "_out"}, {24'h0, out_port}, {24'h0, exp_out});
            sb_q.push_back('{{name, "_status"}, {31'h0, ph}});
            @(negedge clk);
            e = sb_q.pop_front();
            chk(e.name, readdata, e.exp);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        clk_en     = 1'b0;
        reset_n    = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        vecs[0] = '{"wr_data",      1'b1, ADDR_DATA,     32'h0000_000F, 8'h0F};
        vecs[1] = '{"wr_outset",    1'b1, ADDR_OUTSET,   32'h0000_0030, 8'h3F};
        vecs[2] = '{"wr_outclear",  1'b1, ADDR_OUTCLEAR, 32'h0000_0003, 8'h3C};
        vecs[3] = '{"wr_no_cs",     1'b0, ADDR_DATA,     32'h0000_00FF, 8'h3C};
        vecs[4] = '{"wr_upper_ign", 1'b1, ADDR_DATA,     32'hFFFF_FF12, 8'h12};
        vecs[5] = '{"wr_reserved",  1'b1, 3'd6,          32'h0000_00FF, 8'h12};
        vecs[6] = '{"wr_status",    1'b1, ADDR_STATUS,   32'h0000_00FF, 8'h12};
        vecs[7] = '{"wr_data2",     1'b1, ADDR_DATA,     32'h0000_003C, 8'h3C};

        rvecs[0] = '{"rd_data",   ADDR_DATA,         32'h0000_003C};
        rvecs[1] = '{"rd_outset", ADDR_OUTSET,       32'h0};
        rvecs[2] = '{"rd_outclr", ADDR_OUTCLEAR,     32'h0};
        rvecs[3] = '{"rd_rsv6",   3'd6,              32'h0};
        rvecs[4] = '{"rd_rsv7",   3'd7,              32'h0};
        rvecs[5] = '{"rd_mask",   ADDR_BLINK_MASK,   32'h0};
        rvecs[6] = '{"rd_period", ADDR_BLINK_PERIOD, 32'h0};

        // Asynchronous reset with the clock stopped
        #3 reset_n = 1'b0;
        #2;
        chk("rst_out_port", {24'h0, out_port}, {24'h0, RV});
        chk("rst_readdata", readdata, 32'h0);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd("rd_reset_data", ADDR_DATA, 32'h0000_00A5);

        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].addr, vecs[i].wdata, vecs[i].cs);
            chk(vecs[i].name, {24'h0, out_port}, {24'h0, vecs[i].exp_out});
        end
        for (int i = 0; i < 7; i++) begin
            rd(rvecs[i].name, rvecs[i].addr, rvecs[i].exp);
        end

        // Blink with period 3, PRESCALE 4: 12-cycle half-periods
        wr(ADDR_DATA, 32'hFF, 1'b1);
        wr(ADDR_BLINK_MASK, 32'h81, 1'b1);
        rd("rd_mask_set", ADDR_BLINK_MASK, 32'h81);
        wr(ADDR_BLINK_PERIOD, 32'd3, 1'b1);
        blink_run("blink3", 36, 12, 1'b0);
        chk("blink3_dark_end", {24'h0, out_port}, {24'h0, DIM});

        // Period 0 while dark: lit at once and stays lit
        wr(ADDR_BLINK_PERIOD, 32'd0, 1'b0 | 1'b1);
        blink_run("period0", 20, 1000, 1'b0);

        // Period 1: toggles every 4 cycles
        wr(ADDR_BLINK_PERIOD, 32'd1, 1'b1);
        blink_run("period1", 14, 4, 1'b0);
        chk("period1_dark", {24'h0, out_port}, {24'h0, DIM});

        // Rewrite while dark restarts from lit with a full half-period
        wr(ADDR_BLINK_PERIOD, 32'd3, 1'b1);
        blink_run("rewrite3", 14, 12, 1'b0);
        chk("rewrite3_dark", {24'h0, out_port}, {24'h0, DIM});

        // Reset mid-blink, between clock edges
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out_port", {24'h0, out_port}, {24'h0, RV});
        chk("midrst_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd("midrst_status", ADDR_STATUS, 32'h0);
        rd("midrst_period", ADDR_BLINK_PERIOD, 32'h0);
        rd("midrst_mask", ADDR_BLINK_MASK, 32'h0);
        wr(ADDR_BLINK_MASK, 32'hFF, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk("midrst_no_blink", {24'h0, out_port}, {24'h0, RV});
            @(negedge clk);
        end
        rd("midrst_status_end", ADDR_STATUS, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_out_pio.md
Name: led_out_pio

Overview:
Avalon-MM slave output PIO that drives the board LEDs. It is the write-side counterpart of the switch input PIO on the same interconnect. It holds an output data register with atomic set/clear access, and adds a per-bit hardware blink engine driven by a prescaled period timer. Readback uses the same fixed one-cycle read latency as the input PIO, so software drives both PIOs through one access pattern.

Parameters:
DATA_WIDTH, 8, number of output bits (1..32)
RESET_VALUE, 0, data register value after reset
PRESCALE, 50000, clk cycles per blink tick (1 ms at 50 MHz); must be >= 1
PERIOD_WIDTH, 16, width of blink_period register (1..16)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe, qualified by chipselect
writedata  in  32  write data
readdata  out  32  registered read data, latency 1
out_port  out  DATA_WIDTH  LED drive

Behaviour:
- One clock `clk`; reset `reset_n` is asynchronous, active-low. All registers reset on the falling edge of reset_n without waiting for a clock edge.
- Register map (word address):
  - 0 DATA: RW.
  - 1 BLINK_MASK: RW.
  - 2 BLINK_PERIOD: RW, PERIOD_WIDTH bits.
  - 3 STATUS: RO. bit0 = phase; other bits 0.
  - 4 OUTSET: WO.
  - 5 OUTCLEAR: WO.
  - 6, 7: reserved.
- Write accepted on a rising edge when chipselect=1 and write_n=0. Only writedata[DATA_WIDTH-1:0] or [PERIOD_WIDTH-1:0] is used; upper bits are ignored.
- Write effects:
  - DATA: data_reg <= wdata.
  - OUTSET: data_reg <= data_reg | wdata.
  - OUTCLEAR: data_reg <= data_reg & ~wdata.
  - Writes to STATUS or reserved addresses: no effect.
- readdata updates every cycle, regardless of chipselect. readdata <= zero-extended mux(address) of the registers as they stand before that edge.
- Reads of OUTSET, OUTCLEAR and reserved addresses return 0.
- Write/read collision: a write at edge N is visible in readdata at edge N+1.
- out_port = data_reg & ~(blink_mask & {DATA_WIDTH{phase}}), combinational from registers. out_port reflects a write immediately after the write edge.
- Blink timer:
  - presc counts 0..PRESCALE-1 and wraps; tick is asserted when presc == PRESCALE-1.
  - On tick: if per_cnt == blink_period-1, per_cnt <= 0 and phase toggles; otherwise per_cnt increments.
  - One half-period is therefore blink_period*PRESCALE cycles.
- blink_period == 0: timer disabled. presc, per_cnt and phase are held at 0, and out_port = data_reg.
- A write to BLINK_PERIOD (any value) clears presc, per_cnt and phase in the same edge. A rewrite restarts from the lit phase.
- Writes to DATA, BLINK_MASK, OUTSET and OUTCLEAR do not disturb the timer or phase.
- Reset values:
  - data_reg = RESET_VALUE.
  - blink_mask = 0, blink_period = 0, phase = 0, counters = 0.
  - readdata = 0.
  - out_port = RESET_VALUE.
- Reset mid-blink: the timer stops and phase returns to 0 immediately on assertion of reset_n.

Decomposition:
- Package led_out_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_BLINK_MASK=1, ADDR_BLINK_PERIOD=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5.
  - STATUS_PHASE_BIT=0.
- One sub-module, led_blink_timer, contains the prescaler, period counter and phase flop.
  - Inputs: clk, reset_n, period, restart.
  - Output: phase.
- The top level holds the register file, read mux and output gating.

Test Plan:
- Reset behaviour (RESET_VALUE=8'hA5): hold reset_n low with clock stopped -> out_port=8'hA5 and readdata=0 asynchronously. Read addr 0 after release -> 32'h000000A5.
- Set/clear: write DATA=8'h0F, OUTSET=8'h30, OUTCLEAR=8'h03 on consecutive cycles -> out_port 0F, 3F, 3C after each edge. Read addr 0 -> 32'h0000003C. Reads of addrs 4 and 5 -> 0.
- Blink (PRESCALE=4): DATA=8'hFF, BLINK_MASK=8'h81, BLINK_PERIOD=3 -> out_port=FF for 12 cycles, then 7E for 12, then FF. STATUS bit0 tracks phase with 1-cycle read latency.
- Period edge cases: BLINK_PERIOD=0 mid-dark-phase -> out_port=FF next cycle and stays. BLINK_PERIOD=1 -> phase toggles every 4 cycles. Rewriting 3 while dark -> lit immediately, full 12-cycle half-period.
- Bus qualification: write_n=0 with chipselect=0 -> no change. Writedata 32'hFFFF_FF12 to DATA -> out_port=12. Write to addr 6 -> no register change, reads 0.
- Reset mid-operation: assert reset_n while blinking -> out_port=RESET_VALUE, STATUS=0 after release. Blinking stays off until BLINK_PERIOD is written.
